// File: rtl/alien_depth_scheduler_pkg.sv
// Shared constants and types for the alien depth scheduler.
// Field layout matches the output interface's datagram unpacking.
package alien_depth_scheduler_pkg;

  localparam int DEF_OBJ_LIMIT = 16;
  localparam int DEF_R_LEVELS  = 16;
  localparam int DEF_R_W       = 4;
  localparam int QUAD_W        = 2;

  // Per-slot field strides inside the packed datagram vectors.
  localparam int ALIEN_R_STRIDE    = DEF_R_W;
  localparam int ALIEN_QUAD_STRIDE = QUAD_W;
  localparam int ALIEN_ACT_STRIDE  = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SWAP = 2'd2
  } sched_state_t;

endpackage

// File: rtl/alien_depth_scheduler_scan_counter.sv
// Nested bucket/slot counter for the depth scan.
// Holds at the terminal pair; the FSM leaves SCAN there.
module depth_scan_counter #(
  parameter int B_W    = 4,
  parameter int I_W    = 4,
  parameter int B_LAST = 15,
  parameter int I_LAST = 15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           en,
  output logic [B_W-1:0] b,
  output logic [I_W-1:0] i,
  output logic           last
);

  logic i_wrap;

  assign i_wrap = (i == I_W'(I_LAST));
  assign last   = i_wrap && (b == B_W'(B_LAST));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      b <= '0;
      i <= '0;
    end else if (en && !last) begin
      if (i_wrap) begin
        i <= '0;
        b <= b + B_W'(1);
      end else begin
        i <= i + I_W'(1);
      end
    end
  end

endmodule

// File: rtl/alien_depth_scheduler.sv
// Front-to-back ordering of one quadrant's aliens, rebuilt each
// vertical blank by bucket scan and published through a double buffer.
module alien_depth_scheduler
  import alien_depth_scheduler_pkg::*;
#(
  parameter logic [QUAD_W-1:0] QUADRANT = '0,
  parameter int OBJ_LIMIT = DEF_OBJ_LIMIT,
  parameter int R_LEVELS  = DEF_R_LEVELS,
  parameter int IDX_W     = $clog2(OBJ_LIMIT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  input  logic [OBJ_LIMIT-1:0]       obj_active,
  input  logic [OBJ_LIMIT*4-1:0]     obj_r,
  input  logic [OBJ_LIMIT*2-1:0]     obj_quadrant,
  output logic [OBJ_LIMIT*IDX_W-1:0] order_idx,
  output logic [IDX_W:0]             order_count,
  output logic                       order_valid,
  output logic                       busy,
  output logic                       swap_done,
  output logic                       overrun
);

  localparam int R_W   = $clog2(R_LEVELS);
  localparam int CNT_W = IDX_W + 1;

  sched_state_t state;

  logic [OBJ_LIMIT-1:0]       snap_active;
  logic [OBJ_LIMIT*4-1:0]     snap_r;
  logic [OBJ_LIMIT*2-1:0]     snap_quad;
  logic [OBJ_LIMIT*IDX_W-1:0] back;
  logic [CNT_W-1:0]           wr_ptr;

  logic [R_W-1:0]    b;
  logic [IDX_W-1:0]  i;
  logic              last;
  logic              accept;
  logic              hit;
  logic [R_W-1:0]    cur_r;
  logic [QUAD_W-1:0] cur_quad;

  assign accept = (state == IDLE) && frame_start;

  depth_scan_counter #(
    .B_W    (R_W),
    .I_W    (IDX_W),
    .B_LAST (R_LEVELS - 1),
    .I_LAST (OBJ_LIMIT - 1)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (state == SCAN),
    .b     (b),
    .i     (i),
    .last  (last)
  );

  always_comb begin
    cur_r    = snap_r[int'(i)*ALIEN_R_STRIDE +: R_W];
    cur_quad = snap_quad[int'(i)*ALIEN_QUAD_STRIDE +: QUAD_W];
    hit      = (state == SCAN)
            && snap_active[int'(i)*ALIEN_ACT_STRIDE]
            && (cur_quad == QUADRANT)
            && (cur_r == b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      snap_active <= '0;
      snap_r      <= '0;
      snap_quad   <= '0;
      back        <= '0;
      wr_ptr      <= '0;
      order_idx   <= '0;
      order_count <= '0;
      order_valid <= 1'b0;
      busy        <= 1'b0;
      swap_done   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      overrun   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            snap_active <= obj_active;
            snap_r      <= obj_r;
            snap_quad   <= obj_quadrant;
            back        <= '0;
            wr_ptr      <= '0;
            busy        <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          overrun <= frame_start;
          // Buckets visited in ascending r, slots ascending: stable order.
          if (hit) begin
            back[int'(wr_ptr[IDX_W-1:0])*IDX_W +: IDX_W] <= i;
            wr_ptr <= wr_ptr + CNT_W'(1);
          end
          if (last) begin
            state <= SWAP;
          end
        end
        SWAP: begin
          overrun     <= frame_start;
          order_idx   <= back;
          order_count <= wr_ptr;
          order_valid <= 1'b1;
          swap_done   <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alien_depth_scheduler.sv
// Scoreboard bench for alien_depth_scheduler: directed frames,
// overrun, mid-scan reset and empty frame.
module tb_alien_depth_scheduler;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [15:0] obj_active;
  logic [63:0] obj_r;
  logic [31:0] obj_quadrant;
  logic [63:0] order_idx;
  logic [4:0]  order_count;
  logic        order_valid;
  logic        busy;
  logic        swap_done;
  logic        overrun;

  alien_depth_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .obj_active   (obj_active),
    .obj_r        (obj_r),
    .obj_quadrant (obj_quadrant),
    .order_idx    (order_idx),
    .order_count  (order_count),
    .order_valid  (order_valid),
    .busy         (busy),
    .swap_done    (swap_done),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  cnt;
    logic [63:0] idx;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ovr_cnt = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every swap pops one expected order.
  always @(negedge clk) begin
    if (overrun) ovr_cnt = ovr_cnt + 1;
    if (swap_done) begin
      if (q.size() == 0) begin
        check("unexpected_swap", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("swap_cycle", 64'(cyc), 64'(e.cyc));
        check("swap_count", 64'(order_count), 64'(e.cnt));
        check("swap_idx", order_idx, e.idx);
        check("swap_valid", 64'(order_valid), 64'd1);
      end
    end
  end

  task automatic set_slot(input int k, input logic act,
                          input logic [3:0] r, input logic [1:0] qd);
    obj_active[k]           = act;
    obj_r[4*k +: 4]         = r;
    obj_quadrant[2*k +: 2]  = qd;
  endtask

  task automatic clear_slots();
    obj_active   = '0;
    obj_r        = '0;
    obj_quadrant = '0;
  endtask

  task automatic pat_basic();
    clear_slots();
    set_slot(0, 1'b1, 4'd5, 2'd0);
    set_slot(1, 1'b1, 4'd2, 2'd0);
    set_slot(2, 1'b1, 4'd9, 2'd0);
    set_slot(3, 1'b1, 4'd2, 2'd0);
  endtask

  task automatic pat_ties();
    clear_slots();
    for (int k = 0; k < 16; k++)
      set_slot(k, k != 4, 4'd7, (k % 2 == 0) ? 2'd0 : 2'd1);
  endtask

  task automatic pat_three();
    clear_slots();
    set_slot(3, 1'b1, 4'd15, 2'd0);
    set_slot(8, 1'b1, 4'd0, 2'd0);
    set_slot(15, 1'b1, 4'd0, 2'd0);
    set_slot(5, 1'b1, 4'd1, 2'd2);
  endtask

  task automatic pat_empty();
    clear_slots();
    for (int k = 0; k < 16; k++)
      set_slot(k, 1'b1, 4'(k), 2'd3);
  endtask

  task automatic pulse(input logic push, input logic [4:0] cnt,
                       input logic [63:0] idx);
    exp_t e;
    @(negedge clk);
    frame_start = 1'b1;
    if (push) begin
      e.cyc = cyc + 258;
      e.cnt = cnt;
      e.idx = idx;
      q.push_back(e);
    end
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  localparam logic [63:0] ORD_BASIC = 64'h0000_0000_0000_2031;
  localparam logic [63:0] ORD_TIES  = 64'h0000_0000_0ECA_8620;
  localparam logic [63:0] ORD_THREE = 64'h0000_0000_0000_03F8;

  initial begin
    logic nz;
    rst = 1'b1;
    frame_start = 1'b0;
    clear_slots();
    pat_basic();
    @(negedge clk);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    check("rst_wins_busy", 64'(busy), 64'd0);
    check("rst_wins_ovr", 64'(overrun), 64'd0);
    rst = 1'b0;
    frame_start = 1'b0;

    nz = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (order_idx != 0 || order_count != 0 || order_valid ||
          busy || swap_done || overrun) nz = 1'b1;
    end
    check("idle_after_reset", 64'(nz), 64'd0);

    pat_basic();
    pulse(1'b1, 5'd4, ORD_BASIC);
    pat_empty();
    repeat (100) @(negedge clk);
    check("busy_mid_scan", 64'(busy), 64'd1);
    repeat (170) @(negedge clk);
    check("busy_done", 64'(busy), 64'd0);
    check("basic_idx_hold", order_idx, ORD_BASIC);

    pat_ties();
    pulse(1'b1, 5'd7, ORD_TIES);
    repeat (270) @(negedge clk);
    check("ties_count_hold", 64'(order_count), 64'd7);

    ovr_cnt = 0;
    pat_three();
    pulse(1'b1, 5'd3, ORD_THREE);
    pat_basic();
    repeat (98) @(negedge clk);
    pulse(1'b0, 5'd0, 64'd0);
    repeat (200) @(negedge clk);
    check("overrun_pulses", 64'(ovr_cnt), 64'd1);
    check("three_idx_hold", order_idx, ORD_THREE);

    pat_ties();
    pulse(1'b0, 5'd0, 64'd0);
    repeat (48) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_idx", order_idx, 64'd0);
    check("midrst_count", 64'(order_count), 64'd0);
    check("midrst_valid", 64'(order_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    pat_basic();
    pulse(1'b1, 5'd4, ORD_BASIC);
    repeat (270) @(negedge clk);

    pat_empty();
    pulse(1'b1, 5'd0, 64'd0);
    repeat (270) @(negedge clk);
    check("empty_idx_hold", order_idx, 64'd0);
    check("empty_valid_hold", 64'(order_valid), 64'd1);

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alien_depth_scheduler.md
Name: alien_depth_scheduler

Overview:
- Per-quadrant scheduler that orders the frame's alien objects front-to-back (ascending `_r`, ties by ascending index) once per video frame.
- Feeds the pixel-level object selector, so the first matching object in the list is always the closest one.
- Runs during vertical blanking on a snapshot of the datagram's object fields.
- Double-buffered: the published order is stable for the whole active frame.

Parameters:
- QUADRANT, 0, quadrant this instance serves; objects with any other `_quadrant` are excluded.
- OBJ_LIMIT, 16, number of object slots in the datagram.
- R_LEVELS, 16, number of distance values (`_r` is 4 bits).
- IDX_W, 4, width of an object index, equal to $clog2(OBJ_LIMIT).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  single-cycle pulse at the start of vertical blanking.
- obj_active  in  OBJ_LIMIT  `_active` bit of each slot.
- obj_r  in  OBJ_LIMIT*4  `_r` of each slot; slot k occupies bits [4k+3:4k].
- obj_quadrant  in  OBJ_LIMIT*2  `_quadrant` of each slot; slot k occupies bits [2k+1:2k].
- order_idx  out  OBJ_LIMIT*IDX_W  published order; rank j occupies bits [IDX_W*j+IDX_W-1:IDX_W*j].
- order_count  out  IDX_W+1  number of valid ranks, 0..OBJ_LIMIT.
- order_valid  out  1  high once at least one order has been published.
- busy  out  1  high from the cycle after an accepted frame_start through the SWAP cycle.
- swap_done  out  1  one-cycle pulse in the cycle the front buffer updates.
- overrun  out  1  one-cycle pulse when frame_start is ignored.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - order_idx=0, order_count=0, order_valid=0, busy=0, swap_done=0, overrun=0.
  - Snapshot registers and back buffer are cleared.
  - Reset mid-scan aborts the scan; nothing is published.
- IDLE:
  - frame_start=1 latches obj_active, obj_r and obj_quadrant into snapshot registers on that edge.
  - Scan counters are cleared, wr_ptr=0, and the state goes to SCAN.
- SCAN:
  - Bucket counter b runs 0..R_LEVELS-1 as the outer loop; slot counter i runs 0..OBJ_LIMIT-1 as the inner loop.
  - Each cycle examines one (b,i) pair.
  - If the snapshot shows active[i], quadrant[i]==QUADRANT and r[i]==b: back[wr_ptr] <= i and wr_ptr <= wr_ptr+1.
  - After (R_LEVELS-1, OBJ_LIMIT-1) the state goes to SWAP.
  - SCAN lasts exactly R_LEVELS*OBJ_LIMIT cycles, 256 at the defaults.
- SWAP, one cycle:
  - front <= back and order_count <= wr_ptr.
  - order_valid <= 1 and swap_done=1.
  - Next state is IDLE.
- Latency: the new order is visible on outputs 258 cycles after the frame_start edge at the defaults (1 capture + 256 scan + 1 swap).
- Widths:
  - wr_ptr is IDX_W+1 bits and never exceeds OBJ_LIMIT, since each slot matches exactly one bucket.
  - The bucket and slot counters wrap only via the state transition, never silently.
- Unused ranks (j >= order_count) hold 0 in both buffers: back is cleared at capture, and SWAP copies the full buffer.
- frame_start while busy (SCAN or SWAP): ignored, overrun=1 for that cycle, and the scan in progress is unaffected.
- frame_start asserted on the same cycle as rst: reset wins, and no overrun pulse is generated.
- Input changes after capture: no effect until the next accepted frame_start.
- A frame with zero qualifying objects still publishes: order_count=0, order_valid=1, swap_done pulses.

Decomposition:
- Shared package (constants.svh / typedefs.svh):
  - OBJ_LIMIT and the `_r` width.
  - SchedState enum {IDLE, SCAN, SWAP}.
  - The AlienData field offsets, so output_interface and this block unpack the datagram identically.
- Sub-module: depth_scan_counter, the nested b/i counter with a terminal-count output. It keeps the FSM file small.
- The double buffer and snapshot registers stay in the top module.

Test Plan:
- Reset check: rst held 3 cycles, then released with no frame_start → all outputs 0 and busy=0 for 300 cycles.
- Basic sort: slots 0..3 active in QUADRANT with r={5,2,9,2}, others inactive; pulse frame_start → swap_done at cycle +258, order_count=4, order_idx ranks = {1,3,0,2}, order_valid=1.
- Filtering and ties: all 16 slots r=7, even slots in QUADRANT, odd slots in another quadrant, slot 4 inactive → order_count=7, ranks {0,2,6,8,10,12,14}, and ranks 7..15 = 0.
- Overrun: second frame_start 100 cycles after the first → overrun pulses once, and a single swap_done occurs at +258 from the first pulse with the first snapshot's order.
- Mid-scan reset: publish a valid order, start a new scan, assert rst at +50 → outputs 0 next cycle; a subsequent frame_start produces a correct fresh order.
- Empty frame: no qualifying objects → order_count=0, order_valid=1, swap_done pulses; the previous order is replaced by all zeros.
